// File: rtl/reg_file_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file_if : read/write bus of the general-purpose register file. Rev 1.0
// ---------------------------------------------------------------------------
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_addr_a;
  logic [ADDR_WIDTH-1:0] read_addr_b;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic [DATA_WIDTH-1:0] read_data_b;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;

  modport master (
    output read_addr_a, read_addr_b, write_addr, write_data, write_enable,
    input  read_data_a, read_data_b
  );

  modport slave (
    input  read_addr_a, read_addr_b, write_addr, write_data, write_enable,
    output read_data_a, read_data_b
  );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_file : 2 async-read / 1 sync-write register file, async active-low clear.
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   rst,
  reg_file_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (ZERO_REG && (gi == 0)) begin : g_zero
        // Hardwired zero: writes to address 0 simply have nowhere to land.
        assign regs[gi] = '0;
      end else begin : g_store
        logic [DATA_WIDTH-1:0] q;

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            q <= '0;
          end else if (bus.write_enable && (bus.write_addr == ADDR_WIDTH'(gi))) begin
            q <= bus.write_data;
          end
        end

        assign regs[gi] = q;
      end
    end
  endgenerate

  // No write bypass: a same-address read sees the old value until the edge.
  assign bus.read_data_a = regs[bus.read_addr_a];
  assign bus.read_data_b = regs[bus.read_addr_b];

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_file : scoreboard bench for reg_file (32 x 32, ZERO_REG=1). Rev 1.0
// ---------------------------------------------------------------------------
module tb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;

  reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [2**AW];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
  endtask

  task automatic drive_read(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
    exp_t e;
    bus.read_addr_a = a;
    bus.read_addr_b = b;
    e.tag = {tag, "_a"}; e.val = model[a]; exp_q.push_back(e);
    e.tag = {tag, "_b"}; e.val = model[b]; exp_q.push_back(e);
  endtask

  task automatic sample_read();
    exp_t e;
    #1;
    if (exp_q.size() < 2) begin
      check("scoreboard_underflow", DW'(exp_q.size()), DW'(2));
    end else begin
      e = exp_q.pop_front(); check(e.tag, bus.read_data_a, e.val);
      e = exp_q.pop_front(); check(e.tag, bus.read_data_b, e.val);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.write_addr   = a;
    bus.write_data   = d;
    bus.write_enable = 1'b1;
    @(posedge clk);
    if (rst && (a != '0)) model[a] = d;
    #1;
  endtask

  initial begin
    logic [AW-1:0] rst_addrs [3];
    rst_addrs[0] = 5'd0; rst_addrs[1] = 5'd7; rst_addrs[2] = 5'd3;

    clear_model();
    rst              = 1'b0;
    bus.read_addr_a  = '0;
    bus.read_addr_b  = '0;
    bus.write_addr   = 5'd7;
    bus.write_data   = 32'hCAFE_F00D;
    bus.write_enable = 1'b1;

    // Reset held ~200 ns with a live write strobe that must be ignored.
    for (int i = 0; i < 3; i++) begin
      repeat (6) @(negedge clk);
      drive_read($sformatf("rst_hold%0d", i), rst_addrs[i], rst_addrs[i]);
      sample_read();
    end
    repeat (2) @(negedge clk);
    bus.write_enable = 1'b0;
    rst = 1'b1;
    drive_read("rst_write_ignored", 5'd7, 5'd3);
    sample_read();

    // Back-to-back writes then combinational read.
    do_write(5'd7, 32'd327);
    do_write(5'd3, 32'd36827);
    @(negedge clk);
    bus.write_enable = 1'b0;
    drive_read("b2b", 5'd7, 5'd3);
    sample_read();

    // Disabled write across several edges.
    bus.write_addr = 5'd7;
    bus.write_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    drive_read("we_off", 5'd7, 5'd7);
    sample_read();

    // Zero register and top register.
    do_write(5'd0, 32'hFFFF_FFFF);
    do_write(5'd31, 32'h1234_5678);
    @(negedge clk);
    bus.write_enable = 1'b0;
    drive_read("zero_reg", 5'd0, 5'd0);
    sample_read();
    drive_read("reg31", 5'd31, 5'd0);
    sample_read();

    // Same-address read during write: old value before the edge, new after.
    do_write(5'd5, 32'd10);
    @(negedge clk);
    bus.write_addr   = 5'd5;
    bus.write_data   = 32'd20;
    bus.write_enable = 1'b1;
    drive_read("rdw_before", 5'd5, 5'd7);
    sample_read();
    @(posedge clk);
    model[5] = 32'd20;
    drive_read("rdw_after", 5'd5, 5'd3);
    sample_read();
    @(negedge clk);
    bus.write_enable = 1'b0;
    drive_read("same_addr", 5'd5, 5'd5);
    sample_read();

    // Asynchronous reset pulse between edges.
    drive_read("pre_pulse", 5'd3, 5'd7);
    sample_read();
    #2;
    rst = 1'b0;
    clear_model();
    drive_read("async_low", 5'd3, 5'd7);
    sample_read();
    rst = 1'b1;
    @(negedge clk);
    drive_read("post_pulse", 5'd3, 5'd7);
    sample_read();

    // Reset held across a write edge wins.
    do_write(5'd9, 32'hA5A5_5A5A);
    @(negedge clk);
    bus.write_addr   = 5'd9;
    bus.write_data   = 32'h0F0F_0F0F;
    bus.write_enable = 1'b1;
    #4;
    rst = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.write_enable = 1'b0;
    rst = 1'b1;
    drive_read("rst_wins", 5'd9, 5'd31);
    sample_read();

    // First write after release lands on the first edge.
    do_write(5'd9, 32'h8000_0001);
    @(negedge clk);
    bus.write_enable = 1'b0;
    drive_read("post_release", 5'd9, 5'd5);
    sample_read();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/reg_file.md
Name:
reg_file

Overview:
- General-purpose register file for the core datapath.
- Two combinational read ports (A, B) and one synchronous write port.
- Sits between decode (register addresses) and the execute/writeback stages (operands in, result data back).
- Default configuration: 32 registers of 32 bits.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH registers.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 it is an ordinary register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- read_addr_a  input  ADDR_WIDTH  port A read address.
- read_addr_b  input  ADDR_WIDTH  port B read address.
- read_data_a  output  DATA_WIDTH  contents of register read_addr_a.
- read_data_b  output  DATA_WIDTH  contents of register read_addr_b.
- write_addr  input  ADDR_WIDTH  write address.
- write_data  input  DATA_WIDTH  write data.
- write_enable  input  1  active-high write strobe, sampled on rising clk.

Behaviour:
- Reset
  - rst low immediately (asynchronously) clears every register to 0.
  - While rst is low, both read outputs are 0 and writes are ignored.
  - Release is synchronous-safe: the first write takes effect on the first rising clk edge at which rst is high.
- Write
  - On rising clk with rst high and write_enable=1: register[write_addr] <= write_data.
  - write_enable=0: no state change.
  - Write latency is one edge; the new value is visible on the read ports after that edge.
- Read
  - Purely combinational: read_data_x = register[read_addr_x]; no clock latency.
  - An address change updates the output within the same cycle.
- Read during write to the same address
  - No internal bypass: the read port returns the old value until the write edge, then the new value.
  - Forwarding is the pipeline's responsibility.
- Both ports may read the same address simultaneously; both return identical data.
- ZERO_REG=1
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0, regardless of write history.
- Full address range 0..2**ADDR_WIDTH-1 is valid; no wrap-around or out-of-range case exists.
- Data is stored and returned unmodified at DATA_WIDTH bits; no sign or zero extension.
- Reset asserted mid-operation, including on the same edge as a write, wins: all registers read 0 and the write is lost.
- Storage may be flops or distributed RAM, provided the asynchronous-clear behaviour above is met.

Test Plan:
- Reset: drive rst low for 200 ns with reads at addresses 0, 7, 3 -> read_data_a and read_data_b = 0 throughout.
- Back-to-back writes: after rst high, write_enable=1; write 327 to reg 7, then 36827 to reg 3 on the next edge; write_enable=0; set read_addr_a=7, read_addr_b=3 -> read_data_a=327, read_data_b=36827 with no clock edge needed after the address change.
- Disabled write: write_enable=0, write_addr=7, write_data=0xDEADBEEF across several edges -> reg 7 still reads 327.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 -> both ports read 0 at address 0; then write 0x12345678 to reg 31 -> reg 31 reads 0x12345678.
- Same-address read/write: read_addr_a=5 holding 10, write 20 to reg 5 -> read_data_a=10 before the edge, 20 after; read_addr_a=read_addr_b=5 -> both ports read 20.
- Async reset mid-run: with regs 3 and 7 loaded, pulse rst low between clock edges -> outputs drop to 0 without a clock edge; after release, regs 3 and 7 read 0.
